mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single unified memory port between the fetch stage (instruction reads) and the memory stage (loads/stores). It sequences one outstanding memory transaction at a time through a three-state FSM. It gives data accesses priority, with a starvation guard for fetch. It generates the per-stage stall signals that the pipeline top feeds into the fetch and memory stages.

## Interface
- STARVE_MAX, 4: consecutive data grants allowed while fetch waits before fetch is forced to win.
- TIMEOUT_CYC, 255: busy cycles without M_ACK before the transaction is aborted with an error; 8-bit counter, legal range 1..255.
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- F_REQ  in  1  fetch read request; held with F_ADDR until F_ACK.
- F_ADDR  in  64  fetch byte address; bits [1:0] are ignored.
- F_RDATA  out  32  instruction word; valid while F_ACK=1.
- F_ACK  out  1  one-cycle completion pulse to fetch.
- F_ERR  out  1  fetch access fault; valid with F_ACK.
- F_STALL  out  1  F_REQ & ~F_ACK (combinational).
- D_REQ  in  1  data request; held with all D_* payload until D_ACK.
- D_WE  in  1  1 = store, 0 = load.
- D_ADDR  in  64  data byte address; bits [2:0] are ignored by this block.
- D_WDATA  in  64  store data.
- D_WMASK  in  8  store byte enables.
- D_RDATA  out  64  load data; valid while D_ACK=1.
- D_ACK  out  1  one-cycle completion pulse to the memory stage.
- D_ERR  out  1  data access fault; valid with D_ACK.
- MEM_STALL  out  1  D_REQ & ~D_ACK (combinational).
- M_REQ, M_WE  out  1 each  memory-side request and write enable (registered).
- M_ADDR  out  64  memory-side address (registered).
- M_WDATA  out  64  memory-side write data (registered).
- M_WMASK  out  8  memory-side byte enables (registered); 8'h00 for fetch.
- M_RDATA  in  64  memory read data; valid with M_ACK.
- M_ACK  in  1  memory completion pulse.
- M_ERR  in  1  memory fault; valid with M_ACK.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - F_BUSY: fetch transaction in flight.
  - D_BUSY: data transaction in flight.
- Arbitration in IDLE:
  - D_REQ only → D_BUSY.
  - F_REQ only → F_BUSY.
  - Both requesting → D_BUSY, unless starve_cnt == STARVE_MAX, in which case F_BUSY.
- starve_cnt:
  - Increments when data is granted while F_REQ=1.
  - Clears to 0 on any fetch grant.
  - Saturates at STARVE_MAX.
- Grant: on entering a BUSY state, register the M_* payload from the winner and set M_REQ=1. For a fetch grant, M_WE=0, M_WMASK=0, and M_ADDR = {F_ADDR[63:3],3'b0}.
- Completion: in BUSY, when M_ACK=1:
  - Drop M_REQ.
  - Capture read data. For fetch, F_RDATA = F_ADDR[2] ? M_RDATA[63:32] : M_RDATA[31:0]; D_RDATA = M_RDATA.
  - Capture M_ERR into the requester's ERR.
  - Pulse that requester's ACK for one cycle.
  - Return to IDLE.
- Timeout:
  - busy_cnt counts cycles spent in BUSY.
  - At TIMEOUT_CYC with no M_ACK: drop M_REQ, pulse ACK with ERR=1, return to IDLE.
  - A late M_ACK arriving in IDLE is ignored.
- Abandoned request: if the owner's REQ is 0 when completion occurs, the ACK and ERR pulse is suppressed. The memory transaction still finishes.
- RDATA and ERR outputs hold their last captured value when ACK=0. ERR is only meaningful with ACK.

## Timing
- Reset (RESET=0, asynchronous) forces the following immediately, mid-transaction included:
  - FSM to IDLE.
  - starve_cnt=0, busy_cnt=0.
  - M_REQ=0, M_WE=0, M_ADDR=0, M_WDATA=0, M_WMASK=0.
  - F_ACK=0, D_ACK=0, F_ERR=0, D_ERR=0, F_RDATA=0, D_RDATA=0.
- Pending requests are re-arbitrated in the first IDLE cycle after RESET rises.
- Latency:
  - REQ seen in IDLE at cycle N → M_REQ=1 at N+1.
  - M_ACK at cycle K → requester ACK=1 at K+1, with FSM back in IDLE at K+1.
  - A request held through K+1 is re-arbitrated at K+1 → next M_REQ at K+2.
- Memory with single-cycle M_ACK gives a 3-cycle request-to-ACK latency and 1 transaction every 2 cycles.
- M_* outputs are stable while M_REQ=1.
- X_ACK is never high for more than 1 cycle.
- F_ACK and D_ACK are never high in the same cycle.

## Test plan
- Lone fetch: F_REQ, F_ADDR=0x1004, memory acks after 2 cycles with M_RDATA=0xAAAA_BBBB_CCCC_DDDD → M_ADDR=0x1000, M_WMASK=0. F_RDATA=0xAAAABBBB with F_ACK a single pulse. F_STALL high until then.
- Simultaneous F_REQ and D_REQ store (D_ADDR=0x2000, D_WDATA=0x11, D_WMASK=0x01) → data is served first, M_WE=1. Fetch is granted in the IDLE cycle after D_ACK.
- Starvation: D_REQ held continuously with F_REQ=1, STARVE_MAX=4 → exactly 4 data grants, then 1 fetch grant, then data resumes.
- Timeout: TIMEOUT_CYC=8, memory never acks a load → M_REQ drops after 8 busy cycles, D_ACK=1 with D_ERR=1. A late M_ACK is ignored.
- Memory fault: M_ERR=1 with M_ACK on a fetch → F_ACK=1, F_ERR=1. The next fetch with M_ERR=0 returns F_ERR=0.
- Reset mid-transaction: assert RESET=0 while in D_BUSY → M_REQ and all ACKs are 0 immediately. After release with D_REQ still high, the request is re-granted and completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-side signal bundle for the unified memory port arbiter
interface mem_port_arbiter_if;
    logic        f_req;
    logic [63:0] f_addr;
    logic [31:0] f_rdata;
    logic        f_ack;
    logic        f_err;
    logic        f_stall;

    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_wmask;
    logic [63:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        mem_stall;

    logic        m_req;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_wmask;
    logic [63:0] m_rdata;
    logic        m_ack;
    logic        m_err;

    // slave: the arbiter's view
    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_wmask, m_rdata, m_ack, m_err,
        output f_rdata, f_ack, f_err, f_stall, d_rdata, d_ack, d_err, mem_stall,
        output m_req, m_we, m_addr, m_wdata, m_wmask
    );

    // master: pipeline stages plus memory, as seen from outside the arbiter
    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_wmask, m_rdata, m_ack, m_err,
        input  f_rdata, f_ack, f_err, f_stall, d_rdata, d_ack, d_err, mem_stall,
        input  m_req, m_we, m_addr, m_wdata, m_wmask
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-outstanding-transaction arbiter of the unified memory port, data priority with fetch starvation guard
module mem_port_arbiter #(
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int              SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [7:0]      BUSY_LAST  = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, F_BUSY, D_BUSY} state_t;

    state_t        state, state_next;
    logic [SW-1:0] starve_cnt;
    logic [7:0]    busy_cnt;
    logic          grant_f, grant_d, done, expire, owner_req;

    logic          m_req_q, m_we_q;
    logic [63:0]   m_addr_q, m_wdata_q;
    logic [7:0]    m_wmask_q;
    logic          f_ack_q, f_err_q, d_ack_q, d_err_q;
    logic [31:0]   f_rdata_q;
    logic [63:0]   d_rdata_q;

    logic          unused_bits;
    assign unused_bits = ^{bus.f_addr[1:0], bus.d_addr[2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_f    = 1'b0;
        grant_d    = 1'b0;
        done       = 1'b0;
        expire     = 1'b0;
        owner_req  = (state == F_BUSY) ? bus.f_req : bus.d_req;
        case (state)
            IDLE: begin
                if (bus.d_req && !(bus.f_req && starve_cnt == STARVE_LIM)) begin
                    grant_d    = 1'b1;
                    state_next = D_BUSY;
                end else if (bus.f_req) begin
                    grant_f    = 1'b1;
                    state_next = F_BUSY;
                end
            end
            F_BUSY, D_BUSY: begin
                if (bus.m_ack)                  done   = 1'b1;
                else if (busy_cnt == BUSY_LAST) expire = 1'b1;
                if (bus.m_ack || busy_cnt == BUSY_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // busy_cnt is 0 in the first busy cycle, so expiry lands on busy cycle TIMEOUT_CYC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            busy_cnt   <= '0;
        end else begin
            if (grant_f)
                starve_cnt <= '0;
            else if (grant_d && bus.f_req && starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 1'b1;
            busy_cnt <= (state == IDLE) ? 8'd0 : busy_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wmask_q <= '0;
            f_ack_q   <= 1'b0;
            f_err_q   <= 1'b0;
            f_rdata_q <= '0;
            d_ack_q   <= 1'b0;
            d_err_q   <= 1'b0;
            d_rdata_q <= '0;
        end else begin
            f_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            if (grant_f) begin
                m_req_q   <= 1'b1;
                m_we_q    <= 1'b0;
                m_addr_q  <= {bus.f_addr[63:3], 3'b000};
                m_wdata_q <= '0;
                m_wmask_q <= '0;
            end else if (grant_d) begin
                m_req_q   <= 1'b1;
                m_we_q    <= bus.d_we;
                m_addr_q  <= {bus.d_addr[63:3], 3'b000};
                m_wdata_q <= bus.d_wdata;
                m_wmask_q <= bus.d_wmask;
            end else if (done || expire) begin
                m_req_q   <= 1'b0;
            end
            // an owner that dropped its request gets no ACK, but the port is still released
            if ((done || expire) && owner_req) begin
                if (state == F_BUSY) begin
                    f_ack_q <= 1'b1;
                    f_err_q <= expire | bus.m_err;
                    if (done) f_rdata_q <= bus.f_addr[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
                end else begin
                    d_ack_q <= 1'b1;
                    d_err_q <= expire | bus.m_err;
                    if (done) d_rdata_q <= bus.m_rdata;
                end
            end
        end
    end

    assign bus.m_req     = m_req_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.m_wmask   = m_wmask_q;
    assign bus.f_ack     = f_ack_q;
    assign bus.f_err     = f_err_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_err     = d_err_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.f_stall   = bus.f_req & ~f_ack_q;
    assign bus.mem_stall = bus.d_req & ~d_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with STARVE_MAX=4, TIMEOUT_CYC=8
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT_CYC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          kind;       // 0 = memory grant, 1 = fetch ack, 2 = data ack
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic        chk_wdata;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [63:0] mem_rdata = '0;
    logic        mem_err   = 1'b0;
    logic        mem_noack = 1'b0;
    logic        late_ack  = 1'b0;
    int          mem_delay = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void push_grant(input logic we, input logic [63:0] addr,
                                       input logic [63:0] wdata, input logic [7:0] wmask,
                                       input logic chk_wdata);
        exp_t e;
        e.kind = 0; e.we = we; e.addr = addr; e.wdata = wdata; e.wmask = wmask;
        e.chk_wdata = chk_wdata; e.rdata = '0; e.err = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_ack(input int kind, input logic [63:0] rdata, input logic err);
        exp_t e;
        e.kind = kind; e.we = 1'b0; e.addr = '0; e.wdata = '0; e.wmask = '0;
        e.chk_wdata = 1'b0; e.rdata = rdata; e.err = err;
        exp_q.push_back(e);
    endfunction

    // memory model: acks mem_delay cycles after M_REQ is first seen
    initial begin
        int mem_wait;
        mem_wait = 0;
        bus.m_ack = 1'b0; bus.m_err = 1'b0; bus.m_rdata = '0;
        forever begin
            @(negedge clk);
            bus.m_ack = late_ack;
            bus.m_err = 1'b0;
            if (bus.m_req && !mem_noack && rst_n) begin
                if (mem_wait == mem_delay) begin
                    bus.m_ack   = 1'b1;
                    bus.m_err   = mem_err;
                    bus.m_rdata = mem_rdata;
                    mem_wait    = 0;
                end else begin
                    mem_wait++;
                end
            end else begin
                mem_wait = 0;
            end
        end
    end

    // monitor: pops the scoreboard on every grant and ACK, checks pulse/stability invariants
    initial begin
        logic        prev_m_req, prev_f_ack, prev_d_ack;
        logic [136:0] prev_pay;
        exp_t e;
        prev_m_req = 1'b0; prev_f_ack = 1'b0; prev_d_ack = 1'b0; prev_pay = '0;
        forever begin
            @(negedge clk);
            if (bus.m_req && !prev_m_req) begin
                if (exp_q.size() == 0 || exp_q[0].kind != 0) begin
                    check("unexpected_grant", {63'd0, bus.m_req}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_we", {63'd0, bus.m_we}, {63'd0, e.we});
                    check("grant_addr", bus.m_addr, e.addr);
                    check("grant_wmask", {56'd0, bus.m_wmask}, {56'd0, e.wmask});
                    if (e.chk_wdata) check("grant_wdata", bus.m_wdata, e.wdata);
                end
            end
            if (bus.f_ack) begin
                if (exp_q.size() == 0 || exp_q[0].kind != 1) begin
                    check("unexpected_f_ack", {63'd0, bus.f_ack}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("f_rdata", {32'd0, bus.f_rdata}, e.rdata);
                    check("f_err", {63'd0, bus.f_err}, {63'd0, e.err});
                end
                check("f_ack_pulse", {63'd0, prev_f_ack}, 64'd0);
            end
            if (bus.d_ack) begin
                if (exp_q.size() == 0 || exp_q[0].kind != 2) begin
                    check("unexpected_d_ack", {63'd0, bus.d_ack}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("d_rdata", bus.d_rdata, e.rdata);
                    check("d_err", {63'd0, bus.d_err}, {63'd0, e.err});
                end
                check("d_ack_pulse", {63'd0, prev_d_ack}, 64'd0);
                check("ack_exclusive", {63'd0, bus.f_ack}, 64'd0);
            end
            if (bus.m_req && prev_m_req)
                check("m_stable", {55'd0, prev_pay[136:128]} ^ {55'd0, bus.m_we, bus.m_wmask},
                      64'd0);
            prev_m_req = bus.m_req;
            prev_f_ack = bus.f_ack;
            prev_d_ack = bus.d_ack;
            prev_pay   = {bus.m_we, bus.m_wmask, bus.m_addr, bus.m_wdata};
        end
    end

    task automatic wait_f_ack(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.f_ack) seen = 1'b1;
        end
        if (!seen) check("f_ack_timeout", 64'd0, 64'd1);
        bus.f_req = 1'b0;
    endtask

    task automatic wait_d_acks(input int n, input int budget);
        int got;
        got = 0;
        for (int i = 0; i < budget && got < n; i++) begin
            @(negedge clk);
            if (bus.d_ack) got++;
        end
        if (got != n) check("d_ack_timeout", 64'(got), 64'(n));
        bus.d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wmask = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_m_req", {63'd0, bus.m_req}, 64'd0);
        check("rst_m_addr", bus.m_addr, 64'd0);
        check("rst_m_wdata", bus.m_wdata, 64'd0);
        check("rst_acks", {62'd0, bus.f_ack, bus.d_ack}, 64'd0);
        check("rst_rdata", bus.d_rdata | {32'd0, bus.f_rdata}, 64'd0);
        check("rst_stalls", {62'd0, bus.f_stall, bus.mem_stall}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // lone fetch, memory acks after 2 waiting cycles
        mem_delay = 2; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        push_grant(1'b0, 64'h1000, 64'h0, 8'h00, 1'b0);
        push_ack(1, 64'hAAAA_BBBB, 1'b0);
        bus.f_req = 1'b1; bus.f_addr = 64'h1004;
        #1 check("f_stall_on_req", {63'd0, bus.f_stall}, 64'd1);
        @(negedge clk);
        check("grant_latency", {63'd0, bus.m_req}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.f_ack) seen = 1'b1;
            else check("f_stall_wait", {63'd0, bus.f_stall}, 64'd1);
        end
        check("f_ack_seen", {63'd0, seen}, 64'd1);
        check("f_stall_at_ack", {63'd0, bus.f_stall}, 64'd0);
        bus.f_req = 1'b0;
        @(negedge clk);

        // simultaneous store and fetch: data first, fetch granted right after D_ACK
        mem_delay = 0; mem_rdata = 64'h1234_5678_9ABC_DEF0;
        push_grant(1'b1, 64'h2000, 64'h11, 8'h01, 1'b1);
        push_ack(2, 64'h1234_5678_9ABC_DEF0, 1'b0);
        push_grant(1'b0, 64'h3008, 64'h0, 8'h00, 1'b0);
        push_ack(1, 64'h9ABC_DEF0, 1'b0);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h2000;
        bus.d_wdata = 64'h11; bus.d_wmask = 8'h01;
        bus.f_req = 1'b1; bus.f_addr = 64'h3008;
        fork
            begin
                wait_d_acks(1, 20);
                @(negedge clk);
                check("fetch_after_dack", {bus.m_addr[62:0], bus.m_req}, {63'h3008, 1'b1});
            end
            wait_f_ack(30);
        join
        @(negedge clk);

        // starvation guard: 4 data grants, 1 fetch grant, then data resumes
        mem_rdata = 64'h0102_0304_0506_0708;
        for (int i = 0; i < 4; i++) begin
            push_grant(1'b0, 64'h5000, 64'h0, 8'h00, 1'b1);
            push_ack(2, 64'h0102_0304_0506_0708, 1'b0);
        end
        push_grant(1'b0, 64'h4000, 64'h0, 8'h00, 1'b0);
        push_ack(1, 64'h0102_0304, 1'b0);
        push_grant(1'b0, 64'h5000, 64'h0, 8'h00, 1'b1);
        push_ack(2, 64'h0102_0304_0506_0708, 1'b0);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h5000; bus.d_wdata = '0; bus.d_wmask = '0;
        bus.f_req = 1'b1; bus.f_addr = 64'h4004;
        fork
            wait_d_acks(5, 80);
            wait_f_ack(80);
        join
        @(negedge clk);

        // timeout: memory never acks a load; D_RDATA keeps the previous load value
        mem_noack = 1'b1;
        push_grant(1'b0, 64'h6000, 64'h0, 8'h00, 1'b1);
        push_ack(2, 64'h0102_0304_0506_0708, 1'b1);
        bus.d_req = 1'b1; bus.d_addr = 64'h6006;
        n = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.d_ack) seen = 1'b1;
            else if (bus.m_req) n++;
        end
        bus.d_req = 1'b0;
        check("timeout_ack", {63'd0, seen}, 64'd1);
        check("timeout_busy_cycles", 64'(n), 64'd8);
        late_ack = 1'b1;
        @(negedge clk);
        late_ack = 1'b0;
        @(negedge clk);
        check("late_ack_ignored", {61'd0, bus.m_req, bus.f_ack, bus.d_ack}, 64'd0);
        mem_noack = 1'b0;

        // memory fault on a fetch, then a clean fetch
        mem_rdata = 64'hDEAD_BEEF_CAFE_F00D; mem_err = 1'b1;
        push_grant(1'b0, 64'h7000, 64'h0, 8'h00, 1'b0);
        push_ack(1, 64'hCAFE_F00D, 1'b1);
        bus.f_req = 1'b1; bus.f_addr = 64'h7000;
        wait_f_ack(20);
        mem_err = 1'b0;
        push_grant(1'b0, 64'h7000, 64'h0, 8'h00, 1'b0);
        push_ack(1, 64'hDEAD_BEEF, 1'b0);
        bus.f_req = 1'b1; bus.f_addr = 64'h7004;
        wait_f_ack(20);
        @(negedge clk);

        // reset while in D_BUSY, request re-granted after release
        mem_noack = 1'b1; mem_rdata = 64'h0F0F_0F0F_A5A5_A5A5;
        push_grant(1'b1, 64'h8000, 64'h55, 8'hF0, 1'b1);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h8000;
        bus.d_wdata = 64'h55; bus.d_wmask = 8'hF0;
        @(negedge clk);
        check("pre_reset_busy", {63'd0, bus.m_req}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_m_req", {63'd0, bus.m_req}, 64'd0);
        check("midrst_acks", {62'd0, bus.f_ack, bus.d_ack}, 64'd0);
        check("midrst_m_payload", bus.m_addr | bus.m_wdata | {56'd0, bus.m_wmask}, 64'd0);
        check("midrst_rdata", bus.d_rdata | {32'd0, bus.f_rdata}, 64'd0);
        @(negedge clk);
        mem_noack = 1'b0;
        push_grant(1'b1, 64'h8000, 64'h55, 8'hF0, 1'b1);
        push_ack(2, 64'h0F0F_0F0F_A5A5_A5A5, 1'b0);
        rst_n = 1'b1;
        wait_d_acks(1, 20);
        repeat (3) @(negedge clk);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
